assoc_search_ctrl: RTL and testbench

ASSOC_SEARCH_CTRL -- requirements
Module: assoc_search_ctrl

---
 rtl/assoc_pkg.sv | 29 ++
 rtl/tree_add_128bit.sv | 25 ++
 rtl/assoc_search_ctrl.sv | 167 ++++++++++++++++
 tb/tb_assoc_search_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_pkg.sv
// Shared types and width helpers for the associative-search controller.
package assoc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int CHUNK_BITS = 128;
   localparam int POP_W      = 8;

   // Index width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Score width: holds a full-hypervector overlap count (0..CHUNKS*128).
   function automatic int score_w(input int chunks);
      return $clog2(chunks * CHUNK_BITS) + 1;
   endfunction

   // Class-memory address width: class*CHUNKS + chunk.
   function automatic int addr_w(input int num_class, input int chunks);
      return idx_w(num_class * chunks);
   endfunction

endpackage

// File: rtl/tree_add_128bit.sv
// 128-bit population count built as a balanced binary adder tree.
module tree_add_128bit (
   input  logic [127:0] bits,
   output logic [7:0]   sum
);

   logic [1:0] l1 [0:63];
   logic [2:0] l2 [0:31];
   logic [3:0] l3 [0:15];
   logic [4:0] l4 [0:7];
   logic [5:0] l5 [0:3];
   logic [6:0] l6 [0:1];

   // Pairwise reduction, each level one bit wider than the previous.
   always_comb begin
      for (int i = 0; i < 64; i++) l1[i] = {1'b0, bits[2*i]} + {1'b0, bits[2*i+1]};
      for (int i = 0; i < 32; i++) l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
      for (int i = 0; i < 16; i++) l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
      for (int i = 0; i < 8;  i++) l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
      for (int i = 0; i < 4;  i++) l5[i] = {1'b0, l4[2*i]} + {1'b0, l4[2*i+1]};
      for (int i = 0; i < 2;  i++) l6[i] = {1'b0, l5[2*i]} + {1'b0, l5[2*i+1]};
      sum = {1'b0, l6[0]} + {1'b0, l6[1]};
   end

endmodule

// File: rtl/assoc_search_ctrl.sv
// Associative search: streams every chunk of the first N class hypervectors,
// accumulates overlap with the query and reports the best-matching class.
module assoc_search_ctrl
   import assoc_pkg::*;
#(
   parameter int NUM_CLASS = 16,
   parameter int CHUNKS    = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [$clog2(NUM_CLASS):0]         cfg_num_class,
   output logic                               busy,
   output logic                               done,
   output logic                               mem_rd_en,
   output logic [addr_w(NUM_CLASS,CHUNKS)-1:0] mem_addr,
   input  logic [CHUNK_BITS-1:0]              mem_rdata,
   output logic [idx_w(CHUNKS)-1:0]           query_idx,
   input  logic [CHUNK_BITS-1:0]              query_chunk,
   output logic [idx_w(NUM_CLASS)-1:0]        best_class,
   output logic [score_w(CHUNKS)-1:0]         best_score
);

   localparam int CFG_W   = $clog2(NUM_CLASS) + 1;
   localparam int CLS_W   = idx_w(NUM_CLASS);
   localparam int CHK_W   = idx_w(CHUNKS);
   localparam int ADDR_W  = addr_w(NUM_CLASS, CHUNKS);
   localparam int SCORE_W = score_w(CHUNKS);

   state_e              state_q, state_d;
   logic [CLS_W-1:0]    cls_q, cls_d;
   logic [CHK_W-1:0]    chk_q, chk_d;
   logic [CFG_W-1:0]    ncls_q, ncls_d;
   logic                rv_q, rv_d;
   logic [CLS_W-1:0]    rcls_q, rcls_d;
   logic [CHK_W-1:0]    rchk_q, rchk_d;
   logic [SCORE_W-1:0]  acc_q, acc_d;
   logic [CLS_W-1:0]    run_cls_q, run_cls_d;
   logic [SCORE_W-1:0]  run_score_q, run_score_d;
   logic [CLS_W-1:0]    best_class_q, best_class_d;
   logic [SCORE_W-1:0]  best_score_q, best_score_d;

   logic [CHUNK_BITS-1:0] and_vec;
   logic [POP_W-1:0]      pop;
   logic [SCORE_W-1:0]    acc_sum;
   logic                  chk_last, cls_last;

   // Zero classes is meaningless and more than stored cannot be read.
   function automatic logic [CFG_W-1:0] clamp_cfg(input logic [CFG_W-1:0] n);
      if (n == '0)                      return CFG_W'(1);
      else if (n > CFG_W'(NUM_CLASS))   return CFG_W'(NUM_CLASS);
      else                              return n;
   endfunction

   assign and_vec = mem_rdata & query_chunk;

   tree_add_128bit u_pop (
      .bits (and_vec),
      .sum  (pop)
   );

   assign chk_last   = (chk_q == CHK_W'(CHUNKS - 1));
   assign cls_last   = (CFG_W'(cls_q) == ncls_q - CFG_W'(1));
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign mem_rd_en  = (state_q == READ);
   assign mem_addr   = mem_rd_en ? (ADDR_W'(cls_q) * ADDR_W'(CHUNKS) + ADDR_W'(chk_q)) : '0;
   assign query_idx  = mem_rd_en ? chk_q : '0;
   assign best_class = best_class_q;
   assign best_score = best_score_q;

   // Sequencer: issues one read per cycle, tags it with class/chunk for the return.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      chk_d   = chk_q;
      ncls_d  = ncls_q;
      rv_d    = 1'b0;
      rcls_d  = '0;
      rchk_d  = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               cls_d   = '0;
               chk_d   = '0;
               ncls_d  = clamp_cfg(cfg_num_class);
            end
         end
         READ: begin
            rv_d   = 1'b1;
            rcls_d = cls_q;
            rchk_d = chk_q;
            if (chk_last) begin
               chk_d = '0;
               if (cls_last) begin
                  cls_d   = '0;
                  state_d = DRAIN;
               end else begin
                  cls_d = cls_q + CLS_W'(1);
               end
            end else begin
               chk_d = chk_q + CHK_W'(1);
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Accumulate returning chunks; compare each completed class against the running best.
   always_comb begin
      acc_sum      = ((rchk_q == '0) ? '0 : acc_q) + SCORE_W'(pop);
      acc_d        = acc_q;
      run_cls_d    = run_cls_q;
      run_score_d  = run_score_q;
      best_class_d = best_class_q;
      best_score_d = best_score_q;
      if (rv_q) begin
         acc_d = acc_sum;
         if (rchk_q == CHK_W'(CHUNKS - 1)) begin
            if ((rcls_q == '0) || (acc_sum > run_score_q)) begin
               run_cls_d   = rcls_q;
               run_score_d = acc_sum;
            end
         end
      end
      // The last compare lands on the DRAIN edge, so publish its outcome there.
      if (state_q == DRAIN) begin
         best_class_d = run_cls_d;
         best_score_d = run_score_d;
      end
   end

   // State and datapath registers, all cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cls_q        <= '0;
         chk_q        <= '0;
         ncls_q       <= '0;
         rv_q         <= 1'b0;
         rcls_q       <= '0;
         rchk_q       <= '0;
         acc_q        <= '0;
         run_cls_q    <= '0;
         run_score_q  <= '0;
         best_class_q <= '0;
         best_score_q <= '0;
      end else begin
         state_q      <= state_d;
         cls_q        <= cls_d;
         chk_q        <= chk_d;
         ncls_q       <= ncls_d;
         rv_q         <= rv_d;
         rcls_q       <= rcls_d;
         rchk_q       <= rchk_d;
         acc_q        <= acc_d;
         run_cls_q    <= run_cls_d;
         run_score_q  <= run_score_d;
         best_class_q <= best_class_d;
         best_score_q <= best_score_d;
      end
   end

endmodule

// File: tb/tb_assoc_search_ctrl.sv
// Self-checking bench for assoc_search_ctrl with a behavioural memory and score model.
module tb_assoc_search_ctrl;

   localparam int NC = 16;
   localparam int CH = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [4:0]   cfg_num_class = '0;
   logic         busy, done, mem_rd_en;
   logic [6:0]   mem_addr;
   logic [127:0] mem_rdata = '0;
   logic [2:0]   query_idx;
   logic [127:0] query_chunk = '0;
   logic [3:0]   best_class;
   logic [10:0]  best_score;

   logic [127:0] mem [0:NC*CH-1];
   logic [127:0] qry [0:CH-1];
   int           addr_log [$];

   int vectors = 0;
   int errors  = 0;

   assoc_search_ctrl #(.NUM_CLASS(NC), .CHUNKS(CH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_num_class (cfg_num_class),
      .busy          (busy),
      .done          (done),
      .mem_rd_en     (mem_rd_en),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .query_idx     (query_idx),
      .query_chunk   (query_chunk),
      .best_class    (best_class),
      .best_score    (best_score)
   );

   always #5 clk = ~clk;

   // One-cycle-latency class memory and query buffer.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rdata <= mem[mem_addr];
         addr_log.push_back(int'(mem_addr));
      end
      query_chunk <= qry[query_idx];
   end

   function automatic int clampn(input int n);
      return (n == 0) ? 1 : ((n > NC) ? NC : n);
   endfunction

   // Reference: score each class with plain popcounts, keep the first maximum.
   task automatic model(input int n, output int bc, output int bs);
      int nn, s;
      nn = clampn(n);
      bc = 0; bs = -1;
      for (int c = 0; c < nn; c++) begin
         s = 0;
         for (int k = 0; k < CH; k++) s += $countones(mem[c*CH+k] & qry[k]);
         if (s > bs) begin bs = s; bc = c; end
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NC*CH; i++) mem[i] = rnd128();
      for (int k = 0; k < CH; k++) qry[k] = rnd128();
   endtask

   function automatic int addr_seq_bad(input int nn);
      int bad = 0;
      if (addr_log.size() != nn*CH) bad++;
      foreach (addr_log[i]) if (addr_log[i] != i) bad++;
      return bad;
   endfunction

   // Launch one search and observe it until done or a cycle budget runs out.
   task automatic run_search(input int n, input bit hold, output int cyc, output bit got,
                             output int rd_cnt, output bit busy_bad, output bit out_chg);
      logic [3:0]  pc;
      logic [10:0] ps;
      addr_log.delete();
      @(negedge clk);
      start = 1'b1; cfg_num_class = n[4:0];
      pc = best_class; ps = best_score;
      @(posedge clk);
      cyc = 0; got = 1'b0; rd_cnt = 0; busy_bad = 1'b0; out_chg = 1'b0;
      while (!got && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (!hold) start = 1'b0;
         if (mem_rd_en) rd_cnt++;
         if (busy !== 1'b1) busy_bad = 1'b1;
         if (done === 1'b1) got = 1'b1;
         else if (best_class !== pc || best_score !== ps) out_chg = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, mem_rd_en, mem_addr, query_idx, best_class, best_score} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got b%0b d%0b r%0b a%0d q%0d c%0d s%0d want all 0",
                  busy, done, mem_rd_en, mem_addr, query_idx, best_class, best_score);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ramp();
      int cyc, rd; bit got, bb, oc;
      for (int k = 0; k < CH; k++) qry[k] = '1;
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < CH; k++) mem[c*CH+k] = {128{1'b1}} >> (128 - c);
      run_search(16, 1'b0, cyc, got, rd, bb, oc);
      vectors++; if (got !== 1'b1) begin errors++; $display("FAIL ramp_done got %0b want 1", got); end
      vectors++; if (cyc !== 130) begin errors++; $display("FAIL ramp_latency got %0d want 130", cyc); end
      vectors++; if (best_class !== 4'd15) begin errors++; $display("FAIL ramp_class got %0d want 15", best_class); end
      vectors++; if (best_score !== 11'd120) begin errors++; $display("FAIL ramp_score got %0d want 120", best_score); end
      vectors++; if (rd !== 128) begin errors++; $display("FAIL ramp_reads got %0d want 128", rd); end
      vectors++; if (addr_seq_bad(16) !== 0) begin errors++; $display("FAIL ramp_addr_seq got %0d bad want 0", addr_seq_bad(16)); end
      vectors++; if (bb !== 1'b0) begin errors++; $display("FAIL ramp_busy got gap want none"); end
      vectors++; if (oc !== 1'b0) begin errors++; $display("FAIL ramp_early_update got change want hold"); end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL ramp_done_pulse got %0b want 0", done); end
      repeat (3) @(negedge clk);
      vectors++; if ({best_class, best_score} !== {4'd15, 11'd120}) begin
         errors++; $display("FAIL ramp_hold got %0d/%0d want 15/120", best_class, best_score); end
      vectors++; if ({mem_rd_en, mem_addr, query_idx} !== '0) begin
         errors++; $display("FAIL idle_mem got r%0b a%0d q%0d want 0", mem_rd_en, mem_addr, query_idx); end
   endtask

   task automatic test_tie();
      int cyc, rd; bit got, bb, oc;
      for (int k = 0; k < CH; k++) qry[k] = rnd128();
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < CH; k++) mem[c*CH+k] = {~qry[k][127:64], qry[k][63:0]} ^ {64'h0, ~qry[k][63:0] & 64'h0};
      // each chunk overlaps the query in exactly its low 64 bits
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < CH; k++) mem[c*CH+k] = {~qry[k][127:64], 64'hFFFF_FFFF_FFFF_FFFF} & {64'hFFFF_FFFF_FFFF_FFFF, qry[k][63:0]} | {64'h0, ~qry[k][63:0]} & 128'h0;
      for (int k = 0; k < CH; k++) qry[k][63:0] = '1;
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < CH; k++) mem[c*CH+k] = {~qry[k][127:64], 64'hFFFF_FFFF_FFFF_FFFF};
      run_search(16, 1'b0, cyc, got, rd, bb, oc);
      vectors++; if (got !== 1'b1) begin errors++; $display("FAIL tie_done got %0b want 1", got); end
      vectors++; if (best_class !== 4'd0) begin errors++; $display("FAIL tie_class got %0d want 0", best_class); end
      vectors++; if (best_score !== 11'd512) begin errors++; $display("FAIL tie_score got %0d want 512", best_score); end
   endtask

   task automatic test_small();
      int cyc, rd, bc, bs; bit got, bb, oc;
      fill_random();
      for (int k = 0; k < CH; k++) mem[2*CH+k] = qry[k];
      model(3, bc, bs);
      run_search(3, 1'b0, cyc, got, rd, bb, oc);
      vectors++; if (cyc !== 26) begin errors++; $display("FAIL small_latency got %0d want 26", cyc); end
      vectors++; if (best_class !== 4'd2) begin errors++; $display("FAIL small_class got %0d want 2", best_class); end
      vectors++; if (int'(best_score) !== bs) begin errors++; $display("FAIL small_score got %0d want %0d", best_score, bs); end
      vectors++; if (addr_seq_bad(3) !== 0) begin errors++; $display("FAIL small_addr_seq got %0d entries want 0..23", addr_log.size()); end
   endtask

   task automatic test_zero_and_clamp();
      int cyc, rd, bc, bs; bit got, bb, oc;
      fill_random();
      model(0, bc, bs);
      run_search(0, 1'b0, cyc, got, rd, bb, oc);
      vectors++; if (cyc !== 10) begin errors++; $display("FAIL zero_latency got %0d want 10", cyc); end
      vectors++; if (best_class !== 4'd0) begin errors++; $display("FAIL zero_class got %0d want 0", best_class); end
      vectors++; if (int'(best_score) !== bs) begin errors++; $display("FAIL zero_score got %0d want %0d", best_score, bs); end
      vectors++; if (addr_seq_bad(1) !== 0) begin errors++; $display("FAIL zero_addr_seq got %0d entries want 0..7", addr_log.size()); end
      model(20, bc, bs);
      run_search(20, 1'b0, cyc, got, rd, bb, oc);
      vectors++; if (cyc !== 130) begin errors++; $display("FAIL clamp_latency got %0d want 130", cyc); end
      vectors++; if (int'(best_class) !== bc || int'(best_score) !== bs) begin
         errors++; $display("FAIL clamp_result got %0d/%0d want %0d/%0d", best_class, best_score, bc, bs); end
   endtask

   task automatic test_random();
      int cyc, rd, bc, bs, n; bit got, bb, oc;
      for (int it = 0; it < 6; it++) begin
         fill_random();
         n = $urandom_range(0, 17);
         model(n, bc, bs);
         run_search(n, 1'b0, cyc, got, rd, bb, oc);
         vectors++; if (cyc !== clampn(n)*CH + 2) begin
            errors++; $display("FAIL rand_latency n=%0d got %0d want %0d", n, cyc, clampn(n)*CH + 2); end
         vectors++; if (int'(best_class) !== bc || int'(best_score) !== bs) begin
            errors++; $display("FAIL rand_result n=%0d got %0d/%0d want %0d/%0d", n, best_class, best_score, bc, bs); end
      end
   endtask

   task automatic test_midreset();
      int cyc, rd, bc, bs; bit got, bb, oc, seen;
      fill_random();
      @(negedge clk); start = 1'b1; cfg_num_class = 5'd16;
      @(posedge clk);
      for (int i = 0; i < 50; i++) begin @(negedge clk); start = 1'b0; end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, mem_rd_en, mem_addr, query_idx, best_class, best_score} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got b%0b d%0b r%0b a%0d q%0d c%0d s%0d want all 0",
                  busy, done, mem_rd_en, mem_addr, query_idx, best_class, best_score);
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
      vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done got activity want idle"); end
      model(16, bc, bs);
      run_search(16, 1'b0, cyc, got, rd, bb, oc);
      vectors++; if (cyc !== 130 || int'(best_class) !== bc || int'(best_score) !== bs) begin
         errors++; $display("FAIL midreset_fresh got cyc %0d %0d/%0d want 130 %0d/%0d", cyc, best_class, best_score, bc, bs); end
   endtask

   task automatic test_back_to_back();
      int cyc, rd, bc, bs, cyc2; bit got, bb, oc, got2;
      fill_random();
      model(4, bc, bs);
      run_search(4, 1'b1, cyc, got, rd, bb, oc);
      vectors++; if (cyc !== 34 || rd !== 32) begin
         errors++; $display("FAIL b2b_first got cyc %0d reads %0d want 34 32", cyc, rd); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_gap got busy %0b done %0b want 0 0", busy, done); end
      cyc2 = 0; got2 = 1'b0;
      while (!got2 && cyc2 < 2000) begin
         @(negedge clk); cyc2++; start = 1'b0;
         if (done === 1'b1) got2 = 1'b1;
      end
      vectors++; if (cyc2 !== 34) begin errors++; $display("FAIL b2b_second_latency got %0d want 34", cyc2); end
      vectors++; if (int'(best_class) !== bc || int'(best_score) !== bs) begin
         errors++; $display("FAIL b2b_result got %0d/%0d want %0d/%0d", best_class, best_score, bc, bs); end
   endtask

   initial begin
      for (int i = 0; i < NC*CH; i++) mem[i] = '0;
      for (int k = 0; k < CH; k++) qry[k] = '0;
      test_reset();
      test_ramp();
      test_tie();
      test_small();
      test_zero_and_clamp();
      test_random();
      test_midreset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
